// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle radix-2 restoring divider for the core's DIV
//               instruction. It produces one quotient bit per cycle, so the
//               latency is fixed regardless of the operand values. The
//               dividend and divisor are captured on the accepting edge.
//               Signed results truncate toward zero, and the remainder
//               takes the sign of the dividend.
// Ports       :
//   clk            in   1      clock, rising edge
//   reset          in   1      asynchronous, active-high
//   start_i        in   1      request, sampled only while idle
//   is_signed_i    in   1      1: two's-complement divide, 0: unsigned
//   dividend_i     in   WIDTH  Rn operand
//   divisor_i      in   WIDTH  Rm operand
//   busy_o         out  1      operation in progress
//   done_o         out  1      one-cycle pulse, results valid
//   quotient_o     out  WIDTH  registered quotient
//   remainder_o    out  WIDTH  registered remainder
//   div_by_zero_o  out  1      registered, set with done when divisor == 0
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder
    logic [WIDTH-1:0]   dvd_q, dvd_d;      // |dividend|, becomes quotient
    logic [WIDTH-1:0]   dvs_q, dvs_d;      // |divisor|
    logic               qs_q, qs_d;        // quotient sign
    logic               rs_q, rs_d;        // remainder sign
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     shift_w;
    logic [WIDTH:0]     trial_w;
    logic               a_neg_w;
    logic               b_neg_w;

    always_comb begin
        // The trial is one bit wider than the operands. The invariant
        // rem < dvs keeps the shifted value below 2*dvs. Bit WIDTH is
        // therefore a true sign bit, even for a full-range unsigned divisor.
        shift_w = {rem_q, dvd_q[WIDTH-1]};
        trial_w = shift_w - {1'b0, dvs_q};
        a_neg_w = is_signed_i & dividend_i[WIDTH-1];
        b_neg_w = is_signed_i & divisor_i[WIDTH-1];

        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        qs_d       = qs_q;
        rs_d       = rs_q;
        dbz_pend_d = dbz_pend_q;
        quot_d     = quot_q;
        remo_d     = remo_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    // Negating MIN gives back MIN. Read as unsigned, that
                    // value is exactly 2^(WIDTH-1), which is the required
                    // magnitude.
                    dvd_d      = a_neg_w ? -dividend_i : dividend_i;
                    dvs_d      = b_neg_w ? -divisor_i  : divisor_i;
                    qs_d       = a_neg_w ^ b_neg_w;
                    rs_d       = a_neg_w;
                    dbz_pend_d = (divisor_i == '0);
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    state_d    = S_ITER;
                end
            end
            S_ITER: begin
                if (!trial_w[WIDTH]) begin
                    rem_d = trial_w[WIDTH-1:0];
                end else begin
                    rem_d = shift_w[WIDTH-1:0];
                end
                dvd_d = {dvd_q[WIDTH-2:0], ~trial_w[WIDTH]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // With a zero divisor every trial succeeds. The partial
                // remainder then ends as |dividend|. Re-applying the
                // dividend sign restores the raw input, which is the
                // required remainder. Only the quotient needs forcing.
                quot_d  = dbz_pend_q ? '0 : (qs_q ? -dvd_q : dvd_q);
                remo_d  = rs_q ? -rem_q : rem_q;
                dbz_d   = dbz_pend_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            qs_q       <= 1'b0;
            rs_q       <= 1'b0;
            dbz_pend_q <= 1'b0;
            quot_q     <= '0;
            remo_q     <= '0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            qs_q       <= qs_d;
            rs_q       <= rs_d;
            dbz_pend_q <= dbz_pend_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = remo_q;
    assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (WIDTH=32).
//               Every expected value is hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start_i;
    logic             is_signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    int n_checks;
    int n_fail;
    int edges;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .is_signed_i   (is_signed_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request that the next rising edge accepts. Afterwards, scramble
    // the operands so that a design which fails to capture them is exposed.
    task automatic launch_now(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        start_i     = 1'b1;
        is_signed_i = sgn;
        dividend_i  = a;
        divisor_i   = b;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        is_signed_i = ~sgn;
        dividend_i  = 32'hDEAD_BEEF;
        divisor_i   = 32'h0000_0003;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        launch_now(a, b, sgn);
    endtask

    // Count rising edges until done, starting from 'already' edges after the
    // accept edge. The count is bounded so that a missing done cannot hang.
    task automatic wait_done(input int already, output int n);
        n = already;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done_o) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz);
        launch(a, b, sgn);
        check_eq({tag, " busy after accept"}, 32'(busy_o), 32'd1);
        wait_done(0, edges);
        check_eq({tag, " done latency"}, edges, 33);
        check_eq({tag, " busy at done"}, 32'(busy_o), 32'd0);
        check_eq({tag, " quotient"}, quotient_o, eq);
        check_eq({tag, " remainder"}, remainder_o, er);
        check_eq({tag, " dbz"}, 32'(div_by_zero_o), 32'(edbz));
    endtask

    initial begin
        int stray;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        start_i     = 1'b0;
        is_signed_i = 1'b0;
        dividend_i  = '0;
        divisor_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset busy", 32'(busy_o), 32'd0);
        check_eq("reset done", 32'(done_o), 32'd0);
        check_eq("reset quotient", quotient_o, 32'd0);
        check_eq("reset remainder", remainder_o, 32'd0);
        check_eq("reset dbz", 32'(div_by_zero_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: unsigned 100/7.
        run_op("u100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check_eq("done one cycle", 32'(done_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("quotient holds", quotient_o, 32'd14);

        // Test 2: signed operands.
        run_op("s-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run_op("s100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);

        // Test 3: divide by zero, after which a good op clears the flag.
        run_op("dbz", 32'h0000_1234, 32'd0, 1'b0, 32'd0, 32'h0000_1234, 1'b1);
        run_op("s-5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'd0, 32'hFFFF_FFFB, 1'b1);
        run_op("9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        // Test 4: MIN / -1, in signed and in unsigned mode.
        run_op("sMIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        run_op("uMIN/max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
        run_op("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

        // Test 5a: a start pulse while busy is neither taken nor queued.
        launch(32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start_i    = 1'b1;
        dividend_i = 32'd1000;
        divisor_i  = 32'd10;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(10, edges);
        check_eq("busy-start latency", edges, 33);
        check_eq("busy-start quotient", quotient_o, 32'd14);
        check_eq("busy-start remainder", remainder_o, 32'd2);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy_o || done_o) stray++;
        end
        check_eq("no queued op", stray, 0);

        // Test 5b: a start in the done cycle is accepted back to back.
        launch(32'd100, 32'd7, 1'b0);
        wait_done(0, edges);
        check_eq("b2b first quotient", quotient_o, 32'd14);
        launch_now(32'd9, 32'd3, 1'b0);
        wait_done(0, edges);
        check_eq("b2b latency", edges, 33);
        check_eq("b2b quotient", quotient_o, 32'd3);

        // Test 6: reset in mid-operation aborts immediately.
        launch(32'd100, 32'd7, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("abort busy", 32'(busy_o), 32'd0);
        check_eq("abort quotient", quotient_o, 32'd0);
        check_eq("abort remainder", remainder_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done_o) stray++;
        end
        check_eq("abort no done", stray, 0);
        run_op("50/5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
